// File: rtl/float2fxp_s_pipe_if.sv
// Valid/ready stream bundle for the fp32 -> fixed-point converter.
// master drives fp32 words in and accepts results; slave is the converter.
interface float2fxp_s_pipe_if #(
  parameter int unsigned W = 8
) ();

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_fp32;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_fxp;
  logic          out_sat;
  logic          out_nan;

  modport master (
    output in_valid,
    output in_fp32,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_fxp,
    input  out_sat,
    input  out_nan
  );

  modport slave (
    input  in_valid,
    input  in_fp32,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_fxp,
    output out_sat,
    output out_nan
  );

endinterface

// File: rtl/float2fxp_s_pipe.sv
// Two-stage streaming fp32 -> signed Q(WOI.WOF) converter with saturation and NaN flagging.
// Define FLOAT2FXP_RNE_EN for round-to-nearest-even; otherwise the magnitude is truncated.
module float2fxp_s_pipe #(
  parameter int unsigned WOI = 1,
  parameter int unsigned WOF = 7,
  localparam int unsigned W  = WOI + WOF
) (
  input logic               clk,
  input logic               rst,
  float2fxp_s_pipe_if.slave bus_io
);

  localparam logic [31:0]  PosMax = (32'd1 << (W - 1)) - 32'd1;
  localparam logic [31:0]  NegMax = 32'd1 << (W - 1);
  localparam logic [W-1:0] FxpMax = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0] FxpMin = {1'b1, {(W - 1){1'b0}}};

  // Stage 1: unpacked operand
  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_sign_d;
  logic [7:0]  s1_exp_q, s1_exp_d;
  logic [23:0] s1_mant_q, s1_mant_d;
  logic        s1_zero_q, s1_zero_d;
  logic        s1_inf_q, s1_inf_d;
  logic        s1_nan_q, s1_nan_d;

  // Stage 2: converted result, drives the output port directly
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] out_fxp_q, out_fxp_d;
  logic         out_sat_q, out_sat_d;
  logic         out_nan_q, out_nan_d;

  logic s1_load;
  logic s2_load;

  logic [W-1:0] conv_fxp;
  logic         conv_sat;
  logic         conv_nan;

  logic signed [9:0] k;
  logic [4:0]        rsh;
  logic [31:0]       mant32;
  logic [31:0]       int_mag;
  logic [31:0]       rounded;
  logic              round_up;
`ifdef FLOAT2FXP_RNE_EN
  logic              guard_bit;
  logic              sticky_bit;
`endif

  assign s2_load         = !s2_valid_q || bus_io.out_ready;
  assign s1_load         = !s1_valid_q || s2_load;
  assign bus_io.in_ready = s1_load;

  assign bus_io.out_valid = s2_valid_q;
  assign bus_io.out_fxp   = out_fxp_q;
  assign bus_io.out_sat   = out_sat_q;
  assign bus_io.out_nan   = out_nan_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_zero_d  = s1_zero_q;
    s1_inf_d   = s1_inf_q;
    s1_nan_d   = s1_nan_q;
    if (s1_load) begin
      s1_valid_d = bus_io.in_valid;
      if (bus_io.in_valid) begin
        s1_sign_d = bus_io.in_fp32[31];
        s1_exp_d  = bus_io.in_fp32[30:23];
        s1_mant_d = {1'b1, bus_io.in_fp32[22:0]};
        s1_zero_d = (bus_io.in_fp32[30:23] == 8'd0);
        s1_inf_d  = (bus_io.in_fp32[30:23] == 8'hff) && (bus_io.in_fp32[22:0] == 23'd0);
        s1_nan_d  = (bus_io.in_fp32[30:23] == 8'hff) && (bus_io.in_fp32[22:0] != 23'd0);
      end
    end
  end

  // k is the binary exponent of the magnitude measured in output LSBs.
  always_comb begin
    k        = $signed({2'b00, s1_exp_q}) - 10'sd127 + $signed(10'(WOF));
    mant32   = {8'd0, s1_mant_q};
    rsh      = 5'd0;
    int_mag  = 32'd0;
    round_up = 1'b0;
    rounded  = 32'd0;
`ifdef FLOAT2FXP_RNE_EN
    guard_bit  = 1'b0;
    sticky_bit = 1'b0;
`endif
    conv_fxp = '0;
    conv_sat = 1'b0;
    conv_nan = 1'b0;
    if (s1_nan_q) begin
      conv_nan = 1'b1;
    end else if (s1_zero_q || (k < -10'sd2)) begin
      conv_fxp = '0;
    end else if (s1_inf_q || (k >= $signed(10'(W + 1)))) begin
      conv_sat = 1'b1;
      conv_fxp = s1_sign_q ? FxpMin : FxpMax;
    end else begin
      // Here -2 <= k <= W, so the right shift stays within 7..25.
      rsh     = 5'(10'sd23 - k);
      int_mag = mant32 >> rsh;
`ifdef FLOAT2FXP_RNE_EN
      guard_bit  = mant32[rsh - 5'd1];
      sticky_bit = |(mant32 & ((32'd1 << (rsh - 5'd1)) - 32'd1));
      round_up   = guard_bit && (sticky_bit || int_mag[0]);
`endif
      rounded = int_mag + {31'd0, round_up};
      if (!s1_sign_q) begin
        if (rounded > PosMax) begin
          conv_sat = 1'b1;
          conv_fxp = FxpMax;
        end else begin
          conv_fxp = W'(rounded);
        end
      end else begin
        if (rounded > NegMax) begin
          conv_sat = 1'b1;
          conv_fxp = FxpMin;
        end else begin
          conv_fxp = W'(32'd0 - rounded);
        end
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    out_fxp_d  = out_fxp_q;
    out_sat_d  = out_sat_q;
    out_nan_d  = out_nan_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_fxp_d = conv_fxp;
        out_sat_d = conv_sat;
        out_nan_d = conv_nan;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= 8'd0;
      s1_mant_q  <= 24'd0;
      s1_zero_q  <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_nan_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      out_fxp_q  <= '0;
      out_sat_q  <= 1'b0;
      out_nan_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
      s1_zero_q  <= s1_zero_d;
      s1_inf_q   <= s1_inf_d;
      s1_nan_q   <= s1_nan_d;
      s2_valid_q <= s2_valid_d;
      out_fxp_q  <= out_fxp_d;
      out_sat_q  <= out_sat_d;
      out_nan_q  <= out_nan_d;
    end
  end

endmodule
